apb_master_ctrl: RTL and testbench



---
 rtl/apb_master_ctrl_if.sv | 31 +++
 rtl/apb_master_ctrl.sv | 137 +++++++++++++
 tb/tb_apb_master_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake and APB bus signals of the bridge's APB master controller.
// The master modport is the controller's view; the slave modport is the requester/APB-slave side.
interface apb_master_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, Prdata, Pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, Prdata, Pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB master controller: one request at a time, address decode to three slaves,
// SETUP/ACCESS sequencing with Pready wait states and a wait-state timeout.
module apb_master_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  apb_master_ctrl_if.master     bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [2:0]  r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [7:0]  r_wait_cnt;

  logic        w_accept;
  logic        w_timeout;
  logic [2:0]  w_dec_sel;

  always_comb begin
    w_dec_sel = 3'b000;
    case (bus.req_addr[31:26])
      6'b100000: w_dec_sel = 3'b001;
      6'b100001: w_dec_sel = 3'b010;
      6'b100010: w_dec_sel = 3'b100;
      default:   w_dec_sel = 3'b000;
    endcase
  end

  assign w_accept  = bus.req_valid & r_req_ready;
  // This Pready-low cycle is the TIMEOUT-th one spent in ACCESS.
  assign w_timeout = (r_wait_cnt + 8'd1) == LP_TIMEOUT;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_psel      <= 3'b000;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= 32'h0;
      r_pwdata    <= 32'h0;
      r_wait_cnt  <= 8'h0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (w_dec_sel != 3'b000) begin
              r_state    <= S_SETUP;
              r_psel     <= w_dec_sel;
              r_paddr    <= bus.req_addr;
              r_pwrite   <= bus.req_write;
              r_pwdata   <= bus.req_wdata;
              r_wait_cnt <= 8'h0;
            end else begin
              // Unmapped address: answer straight away, the APB bus stays quiet.
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
            end
          end
        end

        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end

        S_ACCESS: begin
          if (bus.Pready) begin
            r_state     <= S_RESP;
            r_psel      <= 3'b000;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_pwrite ? 32'h0 : bus.Prdata;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_timeout) begin
              r_state     <= S_RESP;
              r_psel      <= 3'b000;
              r_penable   <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
            end
          end
        end

        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_psel      <= 3'b000;
          r_penable   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.Pselx     = r_psel;
  assign bus.Penable   = r_penable;
  assign bus.Pwrite    = r_pwrite;
  assign bus.Paddr     = r_paddr;
  assign bus.Pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: transaction-level model predicts every output cycle by cycle,
// with directed cases pinned by literal values and a randomized transaction run.
module tb_apb_master_ctrl;
  localparam int TO = 16;

  logic Hclk    = 1'b0;
  logic Hresetn = 1'b1;

  apb_master_ctrl_if bus();

  apb_master_ctrl #(.TIMEOUT(TO)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  always #5 Hclk = ~Hclk;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected outputs for the current cycle and the model's held APB address/data.
  bit          chk_en = 1'b0;
  logic        e_ready, e_pen, e_rspv, e_err;
  logic [2:0]  e_psel;
  logic [31:0] e_rdata;
  logic [31:0] m_paddr  = 32'h0;
  logic [31:0] m_pwdata = 32'h0;
  logic        m_pwrite = 1'b0;
  bit          hold_v   = 1'b0;

  // Observation counters used by the directed literal checks.
  int          cyc = 0;
  int          pen_cnt = 0, psel_cnt = 0, rsp_cnt = 0;
  int          last_pen_cyc = 0, prev_pen_cyc = 0;
  int          last_acc_cyc = 0, prev_acc_cyc = 0, last_rsp_cyc = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic [2:0]  last_psel = 3'b000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, req, $time);
  endtask

  function automatic logic [2:0] model_sel(input logic [31:0] a);
    int idx;
    if (a >= 32'h8000_0000 && a < 32'h8C00_0000) begin
      idx = int'((a - 32'h8000_0000) >> 26);
      return 3'(1 << idx);
    end
    return 3'b000;
  endfunction

  initial forever begin
    @(posedge Hclk);
    cyc++;
  end

  initial forever begin
    @(negedge Hclk);
    if (bus.Penable === 1'b1) begin
      pen_cnt++;
      prev_pen_cyc = last_pen_cyc;
      last_pen_cyc = cyc;
      last_psel    = bus.Pselx;
    end
    if (bus.Pselx !== 3'b000) psel_cnt++;
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      last_err     = bus.rsp_err;
      last_rdata   = bus.rsp_rdata;
      last_rsp_cyc = cyc;
    end
    if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
      prev_acc_cyc = last_acc_cyc;
      last_acc_cyc = cyc;
    end
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
      chk("Pselx",     32'(bus.Pselx),     32'(e_psel));
      chk("Penable",   32'(bus.Penable),   32'(e_pen));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rspv));
      chk("Paddr",     bus.Paddr,          m_paddr);
      chk("Pwrite",    32'(bus.Pwrite),    32'(m_pwrite));
      chk("Pwdata",    bus.Pwdata,         m_pwdata);
      if (e_rspv) begin
        chk("rsp_err",   32'(bus.rsp_err), 32'(e_err));
        chk("rsp_rdata", bus.rsp_rdata,    e_rdata);
      end
    end
  end

  task automatic set_exp(input logic rdy, input logic [2:0] sel, input logic pen,
                         input logic rv, input logic er, input logic [31:0] rd);
    e_ready = rdy; e_psel = sel; e_pen = pen;
    e_rspv  = rv;  e_err  = er;  e_rdata = rd;
    chk_en  = 1'b1;
  endtask

  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic pr, input logic [31:0] prd);
    @(posedge Hclk);
    #1;
    bus.req_valid = v;  bus.req_write = w;
    bus.req_addr  = a;  bus.req_wdata = d;
    bus.Pready    = pr; bus.Prdata    = prd;
  endtask

  // Cycle while the controller is busy: request lines carry noise that must be ignored.
  task automatic step_busy(input logic pr, input logic [31:0] prd);
    step(hold_v ? 1'b1 : 1'($urandom), 1'($urandom), $urandom, $urandom, pr, prd);
  endtask

  // One transfer: `gap` idle cycles, the acceptance cycle, then the predicted response timeline.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd, input int gap);
    logic [2:0] sel;
    logic       to;
    int         n;
    sel = model_sel(a);
    for (int g = 0; g < gap; g++) begin
      step(1'b0, 1'($urandom), $urandom, $urandom, 1'($urandom), $urandom);
      set_exp(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    step(1'b1, w, a, d, 1'($urandom), $urandom);
    set_exp(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    if (sel == 3'b000) begin
      step_busy(1'($urandom), $urandom);
      set_exp(1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 32'h0);
    end else begin
      step_busy(1'($urandom), $urandom);
      m_paddr = a; m_pwrite = w; m_pwdata = d;
      set_exp(1'b0, sel, 1'b0, 1'b0, 1'b0, 32'h0);
      to = (waits >= TO);
      n  = to ? TO : waits + 1;
      for (int i = 0; i < n; i++) begin
        step_busy(i == waits, (i == waits) ? rd : $urandom);
        set_exp(1'b0, sel, 1'b1, 1'b0, 1'b0, 32'h0);
      end
      step_busy(1'($urandom), $urandom);
      set_exp(1'b0, 3'b000, 1'b0, 1'b1, to, (w || to) ? 32'h0 : rd);
    end
  endtask

  task automatic settle();
    @(negedge Hclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, r0, r1, pe1, waits, gap;
    logic [31:0] a;

    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_addr  = 32'h0; bus.req_wdata = 32'h0;
    bus.Pready    = 1'b0; bus.Prdata    = 32'h0;

    #2 Hresetn = 1'b0;
    #6;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
    chk("rst_Pselx",     32'(bus.Pselx),     32'd0);
    chk("rst_Penable",   32'(bus.Penable),   32'd0);
    chk("rst_Pwrite",    32'(bus.Pwrite),    32'd0);
    chk("rst_Paddr",     bus.Paddr,          32'h0);
    chk("rst_Pwdata",    bus.Pwdata,         32'h0);
    #14 Hresetn = 1'b1;

    // Zero-wait write to slave 0.
    p0 = pen_cnt;
    run_txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 32'h0, 0);
    settle();
    chk("t1_penable_cycles", 32'(pen_cnt - p0),                  32'd1);
    chk("t1_latency",        32'(last_rsp_cyc - last_acc_cyc),   32'd3);
    chk("t1_err",            32'(last_err),                      32'd0);
    chk("t1_psel",           32'(last_psel),                     32'b001);
    chk("t1_pwrite",         32'(bus.Pwrite),                    32'd1);
    chk("t1_pwdata",         bus.Pwdata,                         32'hDEAD_BEEF);

    // Read from slave 1 with two wait states.
    p0 = pen_cnt;
    run_txn(1'b0, 32'h8400_0004, 32'h0, 2, 32'h0000_0019, 1);
    settle();
    chk("t2_access_cycles", 32'(pen_cnt - p0),                32'd3);
    chk("t2_latency",       32'(last_rsp_cyc - last_acc_cyc), 32'd5);
    chk("t2_rdata",         last_rdata,                       32'h0000_0019);
    chk("t2_err",           32'(last_err),                    32'd0);
    chk("t2_psel",          32'(last_psel),                   32'b010);

    // Read from slave 2 with Pready stuck low: timeout.
    p0 = pen_cnt;
    run_txn(1'b0, 32'h8800_0000, 32'h0, 40, 32'h1234_5678, 0);
    settle();
    chk("t3_access_cycles", 32'(pen_cnt - p0),                32'd16);
    chk("t3_latency",       32'(last_rsp_cyc - last_acc_cyc), 32'd18);
    chk("t3_err",           32'(last_err),                    32'd1);
    chk("t3_rdata",         last_rdata,                       32'h0);
    chk("t3_psel_after",    32'(bus.Pselx),                   32'd0);

    // Unmapped address.
    p0 = pen_cnt; s0 = psel_cnt;
    run_txn(1'b0, 32'h9000_0000, 32'h0, 0, 32'hFFFF_FFFF, 0);
    settle();
    chk("t4_penable_cycles", 32'(pen_cnt - p0),                32'd0);
    chk("t4_psel_cycles",    32'(psel_cnt - s0),               32'd0);
    chk("t4_latency",        32'(last_rsp_cyc - last_acc_cyc), 32'd1);
    chk("t4_err",            32'(last_err),                    32'd1);

    // Back-to-back writes with req_valid held high.
    hold_v = 1'b1;
    run_txn(1'b1, 32'h8000_0020, 32'h1111_1111, 0, 32'h0, 0);
    settle();
    r1 = last_rsp_cyc; pe1 = last_pen_cyc;
    run_txn(1'b1, 32'h8000_0024, 32'h2222_2222, 0, 32'h0, 0);
    settle();
    hold_v = 1'b0;
    chk("t5_reaccept",   32'(last_acc_cyc - r1),  32'd1);
    chk("t5_pen_spacing", 32'(last_pen_cyc - pe1), 32'd4);

    // Address-map edges.
    run_txn(1'b0, 32'h8BFF_FFFC, 32'h0, 0, 32'hA5A5_0001, 0);
    settle();
    chk("edge_top_psel", 32'(last_psel), 32'b100);
    chk("edge_top_err",  32'(last_err),  32'd0);
    s0 = psel_cnt;
    run_txn(1'b1, 32'h8C00_0000, 32'h77, 0, 32'h0, 1);
    run_txn(1'b0, 32'h7FFF_FFFC, 32'h0, 0, 32'h0, 0);
    settle();
    chk("edge_unmapped_psel", 32'(psel_cnt - s0), 32'd0);
    chk("edge_unmapped_err",  32'(last_err),      32'd1);

    // Reset asserted during ACCESS.
    step(1'b1, 1'b0, 32'h8000_0100, 32'h5555_5555, 1'b0, 32'h0);
    set_exp(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    step_busy(1'b0, 32'h0);
    m_paddr = 32'h8000_0100; m_pwrite = 1'b0; m_pwdata = 32'h5555_5555;
    set_exp(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0);
    step_busy(1'b0, 32'h0);
    set_exp(1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 32'h0);
    r0 = rsp_cnt;
    @(posedge Hclk);
    #2;
    chk_en = 1'b0;
    bus.req_valid = 1'b0;
    chk("t6_in_access", 32'(bus.Penable), 32'd1);
    Hresetn = 1'b0;
    #1;
    chk("t6_psel_async",   32'(bus.Pselx),     32'd0);
    chk("t6_pen_async",    32'(bus.Penable),   32'd0);
    chk("t6_rspv_async",   32'(bus.rsp_valid), 32'd0);
    chk("t6_ready_async",  32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge Hclk);
    #3;
    Hresetn = 1'b1;
    m_paddr = 32'h0; m_pwrite = 1'b0; m_pwdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, $urandom, $urandom, 1'($urandom), $urandom);
      set_exp(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    settle();
    chk("t6_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    run_txn(1'b0, 32'h8400_0040, 32'h0, 1, 32'hCAFE_F00D, 0);

    // Randomized transactions.
    for (int t = 0; t < 300; t++) begin
      hold_v = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) <= 7)
        a = 32'h8000_0000 + (32'($urandom_range(0, 2)) << 26) + ($urandom & 32'h03FF_FFFF);
      else
        a = $urandom;
      waits = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 3));
      gap   = hold_v ? 0 : int'($urandom_range(0, 2));
      run_txn(1'($urandom), a, $urandom, waits, $urandom, gap);
    end
    hold_v = 1'b0;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    set_exp(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
